sap_1_ir_controller: RTL and testbench
======================================

SAP_1_IR_CONTROLLER -- requirements
Module: SAP_1_IR_CONTROLLER

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port Clk  input  1  system clock; all state updates occur on the rising edge.
REQ-003 Port Clr  input  1  asynchronous active-high reset.
REQ-004 Port instruction  input  8  W-bus byte driven by the MAR/ROM stage while CEbar is low.
REQ-005 Port operand  output  4  IR[3:0], the address field for the MAR.
REQ-006 Port opcode  output  4  IR[7:4], the instruction field.
REQ-007 Port ring  output  6  one-hot T-state: bit0 = T1 through bit5 = T6.
REQ-008 Port con  output  12  control word {Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, EA, Su, EU, LBbar, LObar}, MSB first.
REQ-009 Port hlt  output  1  high while the machine is halted.

Function
REQ-010 The block SHALL hold an 8-bit instruction register (IR), a 6-bit one-hot ring counter and a halt flag.
REQ-011 The ring SHALL advance T1->T2->...->T6->T1 on each rising Clk edge unless halted.
REQ-012 The IR SHALL load instruction on the rising edge that ends T3; the IR SHALL hold its value at all other times.
REQ-013 con SHALL be a combinational decode of ring and IR[7:4]; inactive word = 12'h3E3.
REQ-014 Fetch words (opcode-independent) SHALL be: T1 = 12'h5E3 (Ep, LMbar); T2 = 12'hBE3 (Cp); T3 = 12'h263 (CEbar, LIbar).
REQ-015 LDA (0000) SHALL produce: T4 = 12'h1A3 (EIbar, LMbar); T5 = 12'h2C3 (CEbar, LAbar); T6 = 12'h3E3.
REQ-016 ADD (0001) SHALL produce: T4 = 12'h1A3; T5 = 12'h2E1 (CEbar, LBbar); T6 = 12'h3C7 (LAbar, EU).
REQ-017 SUB (0010) SHALL match ADD except T6 = 12'h3CF (LAbar, EU, Su).
REQ-018 OUT (1110) SHALL produce: T4 = 12'h3F2 (EA, LObar); T5 = T6 = 12'h3E3.
REQ-019 Any other opcode except 1111 SHALL execute as a NOP: T4-T6 = 12'h3E3, and the ring still cycles.
REQ-020 HLT (1111): on the rising edge at which the ring enters T4 with IR[7:4] = 1111, hlt SHALL be set and the ring SHALL freeze at T4.
REQ-021 While halted, con SHALL be 12'h3E3 and the IR SHALL not reload; only Clr SHALL exit the halt.
REQ-022 At most one bit of ring SHALL be high at any time; any illegal ring value SHALL recover to T1 on the next edge.
REQ-023 operand and opcode SHALL always reflect the current IR contents.

Reset
REQ-024 While Clr is high, the block SHALL force ring = 6'b000001, IR = 8'h00, hlt = 0 and con = 12'h3E3, independent of Clk.
REQ-025 Clr asserted mid-instruction (any T-state, halted or not) SHALL abort the instruction immediately, with no partial IR load.
REQ-026 After Clr falls, con SHALL show the T1 word (12'h5E3), and the first rising edge SHALL move the ring to T2.

Verification
REQ-027 Reset, then release and clock 3 edges with instruction = 8'h09 -> ring reads T1, T2, T3 with con = 5E3, BE3, 263; after the 3rd edge (into T4) IR = 09, operand = 9 and con = 1A3.
REQ-028 Drive ADD 8'h1A, then SUB 8'h2B, through full T1-T6 cycles -> T5 con = 2E1 for both; T6 con = 3C7 for ADD and 3CF for SUB; ring returns to T1.
REQ-029 Drive OUT 8'hE0 -> T4 con = 3F2; T5 and T6 con = 3E3.
REQ-030 Drive HLT 8'hF0 -> on entering T4, hlt = 1, ring = 6'b001000 and con = 3E3; after 10 more edges nothing changes; Clr pulse -> ring = T1 and hlt = 0.
REQ-031 Assert Clr asynchronously mid-T5 of LDA 8'h05, between edges -> ring = T1, IR = 00 and con = 3E3 before the next edge.
REQ-032 Drive opcode 8'h70 (undefined) -> T4-T6 con = 3E3, and the ring continues to T1 without halting.

Source files
------------

// File: rtl/sap_1_ir_controller.sv
// SAP-1 instruction register, one-hot T-state ring counter and control-word decoder.
// The ring freezes at T4 on HLT until Clr; con is a pure decode of the ring and the opcode.
module sap_1_ir_controller (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [7:0]  instruction,
  output logic [3:0]  operand,
  output logic [3:0]  opcode,
  output logic [5:0]  ring,
  output logic [11:0] con,
  output logic        hlt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Control word bit order: {Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, EA, Su, EU, LBbar, LObar}
  localparam logic [11:0] CON_IDLE    = 12'h3E3;
  localparam logic [11:0] CON_T1      = 12'h5E3;
  localparam logic [11:0] CON_T2      = 12'hBE3;
  localparam logic [11:0] CON_T3      = 12'h263;
  localparam logic [11:0] CON_MEM_ADR = 12'h1A3;
  localparam logic [11:0] CON_LDA_T5  = 12'h2C3;
  localparam logic [11:0] CON_ALU_T5  = 12'h2E1;
  localparam logic [11:0] CON_ADD_T6  = 12'h3C7;
  localparam logic [11:0] CON_SUB_T6  = 12'h3CF;
  localparam logic [11:0] CON_OUT_T4  = 12'h3F2;

  tstate_e    ring_q, ring_d;
  logic [7:0] ir_q, ir_d;
  logic       hlt_q, hlt_d;
  logic [11:0] con_w;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      ring_q <= T1;
      ir_q   <= '0;
      hlt_q  <= 1'b0;
    end else begin
      ring_q <= ring_d;
      ir_q   <= ir_d;
      hlt_q  <= hlt_d;
    end
  end

  // The halt flag is set on the same edge that loads the IR, so the ring lands
  // on T4 already frozen; any non-one-hot ring value falls back to T1.
  always_comb begin
    ring_d = T1;
    ir_d   = ir_q;
    hlt_d  = hlt_q;
    case (ring_q)
      T1: ring_d = T2;
      T2: ring_d = T3;
      T3: begin
        ring_d = T4;
        ir_d   = instruction;
        hlt_d  = (instruction[7:4] == OP_HLT);
      end
      T4: ring_d = hlt_q ? T4 : T5;
      T5: ring_d = T6;
      T6: ring_d = T1;
      default: ring_d = T1;
    endcase
  end

  always_comb begin
    con_w = CON_IDLE;
    if (!Clr && !hlt_q) begin
      case (ring_q)
        T1: con_w = CON_T1;
        T2: con_w = CON_T2;
        T3: con_w = CON_T3;
        T4: begin
          case (ir_q[7:4])
            OP_LDA, OP_ADD, OP_SUB: con_w = CON_MEM_ADR;
            OP_OUT:                 con_w = CON_OUT_T4;
            default:                con_w = CON_IDLE;
          endcase
        end
        T5: begin
          case (ir_q[7:4])
            OP_LDA:         con_w = CON_LDA_T5;
            OP_ADD, OP_SUB: con_w = CON_ALU_T5;
            default:        con_w = CON_IDLE;
          endcase
        end
        T6: begin
          case (ir_q[7:4])
            OP_ADD:  con_w = CON_ADD_T6;
            OP_SUB:  con_w = CON_SUB_T6;
            default: con_w = CON_IDLE;
          endcase
        end
        default: con_w = CON_IDLE;
      endcase
    end
  end

  assign operand = ir_q[3:0];
  assign opcode  = ir_q[7:4];
  assign ring    = ring_q;
  assign con     = con_w;
  assign hlt     = hlt_q;

endmodule

// File: tb/tb_sap_1_ir_controller.sv
// Directed bench for the SAP-1 IR/controller: fetch, each opcode class, halt and async clear.
`timescale 1ns/1ps
module tb_sap_1_ir_controller;

  logic        Clk;
  logic        Clr;
  logic [7:0]  instruction;
  logic [3:0]  operand;
  logic [3:0]  opcode;
  logic [5:0]  ring;
  logic [11:0] con;
  logic        hlt;

  int unsigned checks;
  int unsigned failures;

  sap_1_ir_controller dut (
    .Clk         (Clk),
    .Clr         (Clr),
    .instruction (instruction),
    .operand     (operand),
    .opcode      (opcode),
    .ring        (ring),
    .con         (con),
    .hlt         (hlt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    instruction = 8'h00;
    #3;
    checks++; if (ring !== 6'b000001) begin failures++; $display("FAIL reset_ring got=%b want=%b", ring, 6'b000001); end
    checks++; if ({opcode, operand} !== 8'h00) begin failures++; $display("FAIL reset_ir got=%h want=00", {opcode, operand}); end
    checks++; if (hlt !== 1'b0) begin failures++; $display("FAIL reset_hlt got=%b want=0", hlt); end
    checks++; if (con !== 12'h3E3) begin failures++; $display("FAIL reset_con got=%h want=3E3", con); end
    @(negedge Clk);
    Clr = 1'b0;
    #1;
    checks++; if (con !== 12'h5E3) begin failures++; $display("FAIL release_con got=%h want=5E3", con); end
  endtask

  task automatic test_fetch_lda();
    logic [5:0]  exp_ring [6];
    logic [11:0] exp_con  [6];
    exp_ring = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
    exp_con  = '{12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3, 12'h5E3};
    instruction = 8'h09;
    checks++; if (ring !== 6'b000001) begin failures++; $display("FAIL lda_t1_ring got=%b want=000001", ring); end
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      checks++; if (ring !== exp_ring[i]) begin failures++; $display("FAIL lda_ring[%0d] got=%b want=%b", i, ring, exp_ring[i]); end
      checks++; if (con !== exp_con[i]) begin failures++; $display("FAIL lda_con[%0d] got=%h want=%h", i, con, exp_con[i]); end
      if (i == 2) begin
        checks++; if (operand !== 4'h9 || opcode !== 4'h0) begin failures++; $display("FAIL lda_ir got=%h%h want=09", opcode, operand); end
      end
    end
  endtask

  task automatic test_add_sub();
    logic [7:0]  instr [2];
    logic [11:0] exp_t6 [2];
    instr  = '{8'h1A, 8'h2B};
    exp_t6 = '{12'h3C7, 12'h3CF};
    for (int unsigned k = 0; k < 2; k++) begin
      instruction = instr[k];
      tick(); tick(); tick();
      checks++; if (con !== 12'h1A3) begin failures++; $display("FAIL alu%0d_t4 got=%h want=1A3", k, con); end
      checks++; if ({opcode, operand} !== instr[k]) begin failures++; $display("FAIL alu%0d_ir got=%h want=%h", k, {opcode, operand}, instr[k]); end
      tick();
      checks++; if (con !== 12'h2E1) begin failures++; $display("FAIL alu%0d_t5 got=%h want=2E1", k, con); end
      tick();
      checks++; if (con !== exp_t6[k]) begin failures++; $display("FAIL alu%0d_t6 got=%h want=%h", k, con, exp_t6[k]); end
      tick();
      checks++; if (ring !== 6'b000001) begin failures++; $display("FAIL alu%0d_wrap got=%b want=000001", k, ring); end
    end
  endtask

  task automatic test_out();
    logic [11:0] exp_con [3];
    exp_con = '{12'h3F2, 12'h3E3, 12'h3E3};
    instruction = 8'hE0;
    tick(); tick();
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++; if (con !== exp_con[i]) begin failures++; $display("FAIL out_con[%0d] got=%h want=%h", i, con, exp_con[i]); end
    end
    tick();
    checks++; if (ring !== 6'b000001) begin failures++; $display("FAIL out_wrap got=%b want=000001", ring); end
  endtask

  task automatic test_nop();
    instruction = 8'h70;
    tick(); tick();
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++; if (con !== 12'h3E3) begin failures++; $display("FAIL nop_con[%0d] got=%h want=3E3", i, con); end
    end
    tick();
    checks++; if (ring !== 6'b000001 || hlt !== 1'b0) begin failures++; $display("FAIL nop_wrap got=ring %b hlt %b want=ring 000001 hlt 0", ring, hlt); end
  endtask

  task automatic test_halt();
    instruction = 8'hF0;
    tick(); tick(); tick();
    checks++; if (hlt !== 1'b1) begin failures++; $display("FAIL hlt_set got=%b want=1", hlt); end
    checks++; if (ring !== 6'b001000) begin failures++; $display("FAIL hlt_ring got=%b want=001000", ring); end
    checks++; if (con !== 12'h3E3) begin failures++; $display("FAIL hlt_con got=%h want=3E3", con); end
    instruction = 8'h12;
    for (int unsigned i = 0; i < 10; i++) tick();
    checks++; if (ring !== 6'b001000 || hlt !== 1'b1) begin failures++; $display("FAIL hlt_hold got=ring %b hlt %b want=ring 001000 hlt 1", ring, hlt); end
    checks++; if ({opcode, operand} !== 8'hF0 || con !== 12'h3E3) begin failures++; $display("FAIL hlt_ir_con got=ir %h con %h want=ir F0 con 3E3", {opcode, operand}, con); end
    #2 Clr = 1'b1;
    #1;
    checks++; if (ring !== 6'b000001 || hlt !== 1'b0) begin failures++; $display("FAIL hlt_clr got=ring %b hlt %b want=ring 000001 hlt 0", ring, hlt); end
    #1 Clr = 1'b0;
    #1;
    checks++; if (con !== 12'h5E3) begin failures++; $display("FAIL hlt_release_con got=%h want=5E3", con); end
  endtask

  task automatic test_async_clear();
    instruction = 8'h05;
    for (int unsigned i = 0; i < 4; i++) tick();
    checks++; if (ring !== 6'b010000 || con !== 12'h2C3) begin failures++; $display("FAIL aclr_t5 got=ring %b con %h want=ring 010000 con 2C3", ring, con); end
    #2 Clr = 1'b1;
    #1;
    checks++; if (ring !== 6'b000001) begin failures++; $display("FAIL aclr_ring got=%b want=000001", ring); end
    checks++; if ({opcode, operand} !== 8'h00) begin failures++; $display("FAIL aclr_ir got=%h want=00", {opcode, operand}); end
    checks++; if (con !== 12'h3E3) begin failures++; $display("FAIL aclr_con got=%h want=3E3", con); end
    #2 Clr = 1'b0;
    #1;
    checks++; if (con !== 12'h5E3) begin failures++; $display("FAIL aclr_release_con got=%h want=5E3", con); end
    tick();
    checks++; if (ring !== 6'b000010) begin failures++; $display("FAIL aclr_first_edge got=%b want=000010", ring); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fetch_lda();
    test_add_sub();
    test_out();
    test_nop();
    test_halt();
    test_async_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
